// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: the default operand width and the operand-select encoding.
package cpu_pkg;

    localparam int DATA_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        SEL_IN0 = 2'b00,
        SEL_IN1 = 2'b01,
        SEL_IN2 = 2'b10,
        SEL_IN3 = 2'b11
    } mux_sel_e;

endpackage

// File: rtl/mux4_comb.sv
// Purely combinational 4-to-1 operand selector.
// The output has no storage element, so it follows select and data within the same time step.
module mux4_comb
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] out
);

    // All four encodings are listed, so this case is complete and infers no latch.
    always_comb begin
        out = in0;
        case (mux_sel_e'(select))
            SEL_IN0: out = in0;
            SEL_IN1: out = in1;
            SEL_IN2: out = in2;
            SEL_IN3: out = in3;
        endcase
    end

endmodule

// File: rtl/data_multiplexer.sv
// CPU operand selector: a zero-latency selected output plus a one-cycle registered copy
// of that output and of the select, for pipeline stages that need a flopped operand.
module data_multiplexer
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [1:0]       select_q
);

    mux4_comb #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in0    (in0),
        .in1    (in1),
        .in2    (in2),
        .in3    (in3),
        .select (select),
        .out    (out)
    );

    // Reset is applied synchronously and only clears the registered copies; out is untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q    <= '0;
            select_q <= SEL_IN0;
        end else begin
            out_q    <= out;
            select_q <= select;
        end
    end

endmodule

// File: tb/tb_data_multiplexer.sv
// Directed self-checking bench for data_multiplexer: combinational select, registered copy, sync reset.
module tb_data_multiplexer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in0, in1, in2, in3;
    logic [1:0] select;
    logic [7:0] out;
    logic [7:0] out_q;
    logic [1:0] select_q;

    int checks;
    int errors;
    int rand_errors;

    data_multiplexer #(
        .WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .select   (select),
        .out      (out),
        .out_q    (out_q),
        .select_q (select_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
        if (s == 2'd0) return a;
        if (s == 2'd1) return b;
        if (s == 2'd2) return c;
        return d;
    endfunction

    initial begin
        logic [7:0] expv;
        int errs_before;

        checks = 0;
        errors = 0;
        rand_errors = 0;
        rst_n  = 1'b0;
        in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
        select = 2'b00;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_q", out_q, 8'h00);
        checkOutput("reset_select_q", {6'b0, select_q}, 8'h00);
        rst_n = 1'b1;

        // Static select sweep
        in0 = 8'h11; in1 = 8'h22; in2 = 8'h33; in3 = 8'h44;
        select = 2'b00; #1 checkOutput("sweep_sel0", out, 8'h11);
        select = 2'b01; #1 checkOutput("sweep_sel1", out, 8'h22);
        select = 2'b10; #1 checkOutput("sweep_sel2", out, 8'h33);
        select = 2'b11; #1 checkOutput("sweep_sel3", out, 8'h44);

        // Data change under a fixed select
        select = 2'b10; in2 = 8'h00; #1 checkOutput("fixed_in2_00", out, 8'h00);
        in2 = 8'hFF; #1 checkOutput("fixed_in2_ff", out, 8'hFF);
        in0 = 8'hA1; in1 = 8'hB2; in3 = 8'hC3; #1 checkOutput("fixed_other_inputs", out, 8'hFF);

        // Randomized sweep
        errs_before = errors;
        for (int i = 0; i < 20; i++) begin
            in0 = 8'($urandom_range(255));
            in1 = 8'($urandom_range(255));
            in2 = 8'($urandom_range(255));
            in3 = 8'($urandom_range(255));
            select = 2'($urandom_range(3));
            expv = pick(select, in0, in1, in2, in3);
            #1 checkOutput("random", out, expv);
            #9;
        end
        rand_errors = errors - errs_before;
        if (rand_errors != 0) begin
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "[TB] random sweep aborted after %0d errors", rand_errors);
        end
        $display("[TB] random sweep ok");

        // Registered path
        @(negedge clk);
        select = 2'b01; in1 = 8'hA5;
        @(posedge clk);
        #1 checkOutput("reg_out_q", out_q, 8'hA5);
        checkOutput("reg_select_q", {6'b0, select_q}, 8'h01);
        in1 = 8'h5A;
        #1 checkOutput("reg_out_now", out, 8'h5A);
        checkOutput("reg_out_q_hold", out_q, 8'hA5);
        @(negedge clk);
        checkOutput("reg_out_q_hold_neg", out_q, 8'hA5);

        // Synchronous reset asserted between edges
        rst_n = 1'b0; select = 2'b11; in3 = 8'h3C;
        #1 checkOutput("rst_out_comb", out, 8'h3C);
        checkOutput("rst_out_q_before_edge", out_q, 8'hA5);
        @(posedge clk);
        #1 checkOutput("rst_out_q_after_edge", out_q, 8'h00);
        checkOutput("rst_select_q_after_edge", {6'b0, select_q}, 8'h00);
        checkOutput("rst_out_comb_after_edge", out, 8'h3C);

        // Reset release
        @(negedge clk);
        rst_n = 1'b1; select = 2'b00; in0 = 8'h7E;
        @(posedge clk);
        #1 checkOutput("release_out_q", out_q, 8'h7E);
        checkOutput("release_select_q", {6'b0, select_q}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
